// File: rtl/byte_ser_pkg.sv
// Shared definitions for the byte serializer: FSM state encodings and default word width.
package byte_ser_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry hold register in front of the shifter; owns the valid flag and s_ready.
module ser_hold_reg
  import byte_ser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             load,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_valid,
  output logic             hold_valid_next_c
);

  logic take;

  assign take              = s_valid & s_ready;
  assign hold_valid_next_c = take | (hold_valid & ~load);

  // Valid flag and ready flop; ready mirrors the next valid so it never depends on s_valid in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      s_ready    <= 1'b0;
    end else begin
      hold_valid <= hold_valid_next_c;
      s_ready    <= ~hold_valid_next_c;
    end
  end

  // Data capture on an accepted transfer only.
  always_ff @(posedge clk) begin
    if (take) begin
      hold_data <= s_data;
    end
  end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer and gapless back-to-back frames.
// Optional feature: define BYTE_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module byte_serializer
  import byte_ser_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_last,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  ser_state_t       state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ser_out_n, ser_valid_n, frame_last_n;
  logic             load;
  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic             hold_valid_next_c;
`ifdef BYTE_SERIALIZER_PARITY_EN
  logic             par, par_n;
`endif

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk              (clk),
    .rst              (rst),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .load             (load),
    .hold_data        (hold_data),
    .hold_valid       (hold_valid),
    .hold_valid_next_c(hold_valid_next_c)
  );

  // State, shifter, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sh         <= '0;
      cnt        <= '0;
      ser_out    <= IDLE_LEVEL;
      ser_valid  <= 1'b0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      cnt        <= cnt_n;
      ser_out    <= ser_out_n;
      ser_valid  <= ser_valid_n;
      frame_last <= frame_last_n;
      busy       <= (state_n != IDLE) | hold_valid_next_c;
`ifdef BYTE_SERIALIZER_PARITY_EN
      par        <= par_n;
`endif
    end
  end

  // Next-state, shift and output decode; a load pulls the held word into the shifter.
  always_comb begin
    state_n      = state;
    sh_n         = sh;
    cnt_n        = cnt;
    ser_out_n    = IDLE_LEVEL;
    ser_valid_n  = 1'b0;
    frame_last_n = 1'b0;
    load         = 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
    par_n        = par;
`endif
    unique case (state)
      IDLE: begin
        if (hold_valid) begin
          load    = 1'b1;
          sh_n    = hold_data;
          cnt_n   = '0;
          state_n = SHIFT;
`ifdef BYTE_SERIALIZER_PARITY_EN
          par_n   = ^hold_data;
`endif
        end
      end
      SHIFT: begin
        ser_valid_n = 1'b1;
        ser_out_n   = MSB_FIRST ? sh[WIDTH-1] : sh[0];
        sh_n        = MSB_FIRST ? (sh << 1) : (sh >> 1);
        cnt_n       = cnt + CNT_W'(1);
        if (cnt == LAST_BIT) begin
          cnt_n = '0;
`ifdef BYTE_SERIALIZER_PARITY_EN
          state_n = PARITY;
`else
          frame_last_n = 1'b1;
          if (hold_valid) begin
            load = 1'b1;
            sh_n = hold_data;
          end else begin
            state_n = IDLE;
          end
`endif
        end
      end
`ifdef BYTE_SERIALIZER_PARITY_EN
      PARITY: begin
        ser_valid_n  = 1'b1;
        ser_out_n    = par;
        frame_last_n = 1'b1;
        cnt_n        = '0;
        if (hold_valid) begin
          load    = 1'b1;
          sh_n    = hold_data;
          par_n   = ^hold_data;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
`endif
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = shift MSB first, 0 = shift LSB first.
REQ-003 Parameter IDLE_LEVEL, default 1'b0, ser_out level when no bit is valid.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_data  input  WIDTH  parallel word to serialize.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_ready  output  1  block can accept a word.
REQ-009 ser_out  output  1  serial bit stream for the downstream pattern detector.
REQ-010 ser_valid  output  1  ser_out carries a frame bit this cycle.
REQ-011 frame_last  output  1  ser_out is the last bit of the current frame.
REQ-012 busy  output  1  shifter active or hold register occupied.

Function
REQ-013 Transfer SHALL occur on a rising edge with s_valid=1 and s_ready=1; the word SHALL be written to a one-entry hold register.
REQ-014 s_ready SHALL equal NOT(hold valid), taken from a flop with no combinational path from s_valid; it SHALL be 0 while rst=1.
REQ-015 s_data SHALL be ignored when s_ready=0; the upstream holds s_data stable until transfer.
REQ-016 FSM states SHALL be IDLE, SHIFT and PARITY; PARITY exists only per REQ-027.
REQ-017 IDLE: if hold valid, the shifter SHALL load the hold word, clear hold valid, and enter SHIFT on the same edge.
REQ-018 At each SHIFT edge, ser_out SHALL be registered with the next bit and ser_valid SHALL be 1; the first bit SHALL appear in the cycle after the load edge.
REQ-019 Latency SHALL be exactly 2 edges from transfer to first valid bit when the block is IDLE with hold empty.
REQ-020 A frame SHALL be WIDTH consecutive valid bits, ordered per MSB_FIRST; frame_last SHALL be 1 only on the final frame bit.
REQ-021 On the edge that outputs the final bit, if hold is valid, the next word SHALL load so its first bit follows with no gap; otherwise the FSM returns to IDLE.
REQ-022 A transfer into hold and a shift of the current word on the same edge SHALL both take effect.
REQ-023 When ser_valid=0, ser_out SHALL equal IDLE_LEVEL and frame_last SHALL be 0.
REQ-024 busy SHALL be 1 when state is not IDLE or hold is valid.

Reset
REQ-025 While rst=1, the following SHALL hold after the edge: state IDLE, hold empty, bit counter 0, ser_out=IDLE_LEVEL, ser_valid=0, frame_last=0, busy=0, s_ready=0.
REQ-026 Reset mid-frame SHALL discard the in-flight and held words with no partial-frame continuation; s_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 With macro BYTE_SERIALIZER_PARITY_EN defined, each frame SHALL be WIDTH data bits followed by one even-parity bit (XOR of the data bits) in state PARITY with ser_valid=1; frame_last SHALL move to the parity bit; gapless loading per REQ-021 SHALL occur on the parity edge.
REQ-028 Without BYTE_SERIALIZER_PARITY_EN, the PARITY state and its logic SHALL be absent and frames SHALL be WIDTH bits.

Structure
REQ-029 Shared package byte_ser_pkg SHALL hold the state encodings (IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2) and the default WIDTH constant.
REQ-030 The hold register with its valid flag and s_ready generation SHALL be a sub-module ser_hold_reg; the FSM, shifter and counter SHALL remain in byte_serializer.

Verification
REQ-031 Default parameters, single transfer 8'hA5 at edge N -> ser_out 1,0,1,0,0,1,0,1 valid in the cycles after edges N+2..N+9, with frame_last on the last bit, then IDLE_LEVEL.
REQ-032 Back-to-back 8'h90 then 8'h9F -> 16 contiguous valid bits 1001000010011111, with no gap and frame_last on bits 8 and 16.
REQ-033 s_valid held high with 3 words queued -> s_ready=0 while hold is full, each word is sent exactly once in order, and s_data changes while s_ready=0 are ignored.
REQ-034 MSB_FIRST=0, word 8'h01 -> ser_out 1,0,0,0,0,0,0,0.
REQ-035 rst asserted after 3 bits of 8'hFF with 8'h0F held -> outputs match REQ-025 next cycle, and neither word is emitted after release.
REQ-036 BYTE_SERIALIZER_PARITY_EN defined, word 8'h07 -> 9-bit frame 0,0,0,0,0,1,1,1 then parity 1, with frame_last on the parity bit.
